pci_bus_arbiter: RTL and testbench

- Central PCI arbiter that shares the PCI bus (FRAME, IRDY, AD, CBE) among NUM_MASTERS initiators using active-low REQ/GNT pairs.
- Monitors bus idle from FRAME and IRDY.
- Grants round-robin, guarantees one turnaround cycle between different owners, and reclaims unused grants after a timeout.
- Sits beside the PCI target and its initiators at the top level.

---
 rtl/pci_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_pci_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin PCI REQ/GNT arbiter with turnaround and grant timeout; define ARB_PARK_EN to park the bus on PARK_MASTER
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic                           frame_i,
  input  logic                           irdy_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o,
  output logic                           owner_valid_o,
  output logic                           bus_idle_o
);
  localparam int W  = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(GNT_TIMEOUT + 1);

`ifdef ARB_PARK_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_PARK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;
  logic unused_park;
  assign unused_park = ^W'(PARK_MASTER);
`endif

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [W-1:0]           owner_q;
  logic [W-1:0]           ptr_q;
  logic [TW-1:0]          timer_q;
  logic                   valid_q;
  logic                   idle_q;
  logic [W-1:0]           win;
  logic [W-1:0]           idx;
  logic [W-1:0]           nxt;
  logic [NUM_MASTERS-1:0] own_oh;
  logic                   any_req;
  logic                   own_req;
  logic                   oth;

  assign any_req = ~&req_i;
  assign own_oh  = NUM_MASTERS'(1) << owner_q;
  assign own_req = ~req_i[owner_q];
  assign oth     = |(~req_i & ~own_oh);
  assign nxt     = (owner_q == W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

  // Round-robin winner: scan downwards so the requester closest after ptr_q wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = W'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!req_i[idx]) win = idx;
    end
  end

  // Arbitration FSM; grant, owner, valid and bus-idle are all registered here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      idle_q <= frame_i & irdy_i;
      case (state_q)
        S_IDLE:
          if (any_req) begin
            gnt_q   <= ~(NUM_MASTERS'(1) << win);
            owner_q <= win;
            valid_q <= 1'b1;
            timer_q <= '0;
            state_q <= S_GRANT;
          end
`ifdef ARB_PARK_EN
          else begin
            gnt_q   <= ~(NUM_MASTERS'(1) << PARK_MASTER);
            owner_q <= W'(PARK_MASTER);
            valid_q <= 1'b1;
            state_q <= S_PARK;
          end
        S_PARK:
          if (!frame_i) begin
            ptr_q   <= nxt;
            state_q <= S_BUSY;
          end else if (oth) begin
            gnt_q   <= '1;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (own_req) begin
            timer_q <= '0;
            state_q <= S_GRANT;
          end
`endif
        S_GRANT:
          if (!frame_i) begin
            ptr_q   <= nxt;
            state_q <= S_BUSY;
          end else if (!own_req || timer_q == TW'(GNT_TIMEOUT - 1)) begin
            gnt_q   <= '1;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
            if (own_req) ptr_q <= nxt;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        S_BUSY:
          if (frame_i && irdy_i) begin
            if (own_req && !oth) begin
              gnt_q   <= ~own_oh;
              valid_q <= 1'b1;
              timer_q <= '0;
              state_q <= S_GRANT;
            end else begin
              gnt_q   <= '1;
              valid_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (!own_req || oth) begin
            gnt_q   <= '1;
            valid_q <= 1'b0;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = valid_q;
  assign bus_idle_o    = idle_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed stimulus checked against a transaction-level arbiter model every cycle
module tb_pci_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       ov;
  logic       bidle;
  int         vectors = 0;
  int         miscompares = 0;

  pci_bus_arbiter #(.NUM_MASTERS(N), .PARK_MASTER(0), .GNT_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .frame_i(frame), .irdy_i(irdy),
    .gnt_o(gnt), .owner_o(owner), .owner_valid_o(ov), .bus_idle_o(bidle)
  );

  always #5 clk = ~clk;

  // Model: who holds the grant (-1 none), whether a transaction is running, rotation start, idle-grant age.
  int m_g, m_own, m_ptr, m_tmr;
  bit m_busy, m_bidle;

  always @(posedge clk or negedge rst_n) begin
    int ng, nown, nptr, ntmr;
    bit nbusy, others, mine;
    if (!rst_n) begin
      m_g <= -1; m_own <= 0; m_ptr <= 0; m_tmr <= 0; m_busy <= 0; m_bidle <= 1;
    end else begin
      ng = m_g; nown = m_own; nptr = m_ptr; ntmr = m_tmr; nbusy = m_busy;
      mine = (req[m_own] == 1'b0);
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_own && req[j] == 1'b0) others = 1;
      if (m_busy) begin
        if (frame && irdy) begin
          nbusy = 0;
          if (mine && !others) begin ng = m_own; ntmr = 0; end else ng = -1;
        end else if (!mine || others) ng = -1;
      end else if (m_g >= 0) begin
        if (!frame) begin nbusy = 1; nptr = (m_own + 1) % N; end
        else if (!mine) ng = -1;
        else if (m_tmr == TO - 1) begin ng = -1; nptr = (m_own + 1) % N; end
        else ntmr = m_tmr + 1;
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N] == 1'b0) begin ng = (m_ptr + k) % N; nown = ng; ntmr = 0; end
      end
      m_g <= ng; m_own <= nown; m_ptr <= nptr; m_tmr <= ntmr; m_busy <= nbusy; m_bidle <= frame & irdy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle compare against the model plus the grant invariants.
  logic [3:0] prev_gnt = 4'hf;
  always @(negedge clk) begin
    logic [3:0] eg;
    eg = 4'hf;
    if (m_g >= 0) eg[m_g] = 1'b0;
    check("model_gnt", {28'd0, gnt}, {28'd0, eg});
    check("model_owner", {30'd0, owner}, m_own);
    check("model_valid", {31'd0, ov}, {31'd0, m_g >= 0});
    check("model_bus_idle", {31'd0, bidle}, {31'd0, m_bidle});
    check("onehot_gnt", $countones(~gnt) <= 1, 1);
    check("no_direct_handoff", (prev_gnt != 4'hf && gnt != 4'hf && gnt != prev_gnt), 0);
    prev_gnt = gnt;
  end

  task automatic step(input logic [3:0] r, input logic f, input logic i);
    req = r; frame = f; irdy = i;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'hf; frame = 1'b1; irdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req = 4'hf; frame = 1'b1; irdy = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_gnt", gnt, 4'hf);
    check("reset_owner", owner, 0);
    check("reset_valid", ov, 0);
    check("reset_bus_idle", bidle, 1);
    rst_n = 1'b1;
    // First grant one clock after master 0 requests, then FRAME moves it to BUSY.
    step(4'b1110, 1, 1);
    check("first_gnt", gnt, 4'b1110);
    check("first_valid", ov, 1);
    step(4'b1110, 0, 1);
    check("busy_keep_gnt", gnt, 4'b1110);
    step(4'b1110, 0, 0);
    step(4'b1111, 1, 0);
    check("busy_release_gnt", gnt, 4'hf);
    step(4'b1111, 1, 1);
    step(4'b1010, 1, 1);
    check("ptr_after_busy_owner", owner, 2);
    check("ptr_after_busy_gnt", gnt, 4'b1011);
    step(4'b1111, 1, 1);
    check("withdraw_gnt", gnt, 4'hf);
    // Round robin with everyone requesting.
    do_reset();
    for (int e = 0; e < 5; e++) begin
      n = 0;
      while (gnt == 4'hf && n < 10) begin n++; step(4'h0, 1, 1); end
      check("rr_owner", owner, e % N);
      step(4'h0, 0, 0);
      step(4'h0, 0, 0);
      step(4'h0, 1, 0);
    end
    // Master 2 never drives FRAME: grant withdrawn after TO cycles, master 3 next.
    do_reset();
    step(4'b0011, 1, 1);
    check("to_first_gnt", gnt, 4'b1011);
    n = 0;
    while (gnt == 4'b1011 && n < 40) begin n++; step(4'b0011, 1, 1); end
    check("to_low_cycles", n, TO);
    check("to_turnaround", gnt, 4'hf);
    step(4'b0011, 1, 1);
    check("to_next_gnt", gnt, 4'b0111);
    check("to_next_owner", owner, 3);
    // Master 1 in BUSY loses its grant when master 3 requests.
    do_reset();
    step(4'b1101, 1, 1);
    step(4'b1101, 0, 1);
    check("pre_gnt", gnt, 4'b1101);
    step(4'b0101, 0, 0);
    check("preempt_gnt", gnt, 4'hf);
    step(4'b0101, 1, 0);
    step(4'b0101, 1, 1);
    check("preempt_turnaround", gnt, 4'hf);
    step(4'b0101, 1, 1);
    check("preempt_next", gnt, 4'b0111);
    // Asynchronous reset in the middle of a BUSY transaction.
    do_reset();
    step(4'b1011, 1, 1);
    step(4'b1011, 0, 1);
    check("arst_pre_gnt", gnt, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 4'hf);
    check("arst_valid", ov, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h0, 1, 1);
    check("arst_restart_gnt", gnt, 4'b1110);
    check("arst_restart_owner", owner, 0);
    step(4'hf, 1, 1);
    step(4'hf, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
